// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter slice.
package pc_pkg;

  localparam int unsigned PC_W = 16;
  localparam int unsigned IN_W = 8;
  localparam logic [PC_W-1:0] RESET_VEC = 16'h0000;

  typedef logic [PC_W-1:0] pc_t;
  typedef logic [IN_W-1:0] pc_in_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD
  } pc_op_e;

endpackage

// File: rtl/program_counter_if.sv
// Control/data bundle between the control unit (master) and the program counter (slave).
// PC_WRAP_FLAG_EN adds the registered wrap pulse.
interface program_counter_if;
  import pc_pkg::*;

  pc_in_t PC_in;
  logic   LD;
  logic   Inc;
  pc_t    PC_out;
`ifdef PC_WRAP_FLAG_EN
  logic   wrap;

  modport master (output PC_in, output LD, output Inc, input PC_out, input wrap);
  modport slave  (input PC_in, input LD, input Inc, output PC_out, output wrap);
`else
  modport master (output PC_in, output LD, output Inc, input PC_out);
  modport slave  (input PC_in, input LD, input Inc, output PC_out);
`endif

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: hold, increment by STEP, or zero-extended load.
// PC_WRAP_FLAG_EN adds the wrap_o condition output.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  pc_op_e op_i,
  input  pc_t    pc_i,
  input  pc_in_t pc_in_i,
`ifdef PC_WRAP_FLAG_EN
  output logic   wrap_o,
`endif
  output pc_t    pc_next_o
);

  pc_t pc_inc;

  always_comb begin
    pc_inc = pc_i + pc_t'(STEP);
    unique case (op_i)
      PC_LOAD: pc_next_o = {{(PC_W - IN_W){1'b0}}, pc_in_i};
      PC_INC:  pc_next_o = pc_inc;
      default: pc_next_o = pc_i;
    endcase
  end

`ifdef PC_WRAP_FLAG_EN
  // Only an increment out of all-ones counts; loads can never raise it.
  always_comb begin
    wrap_o = (op_i == PC_INC) && (pc_i == '1) && (pc_inc == '0);
  end
`endif

endmodule

// File: rtl/program_counter.sv
// 16-bit program counter: op decode (LD > Inc > hold) and the async-reset state register.
// Optional PC_WRAP_FLAG_EN adds a one-cycle registered wrap pulse on bus.wrap.
module program_counter #(
  parameter pc_pkg::pc_t RESET_VEC = pc_pkg::RESET_VEC,
  parameter int unsigned STEP      = 1
) (
  input logic              clk,
  input logic              rst,
  program_counter_if.slave bus
);
  import pc_pkg::*;

  pc_op_e op;
  pc_t    pc_d, pc_q;

  always_comb begin
    if (bus.LD) begin
      op = PC_LOAD;
    end else if (bus.Inc) begin
      op = PC_INC;
    end else begin
      op = PC_HOLD;
    end
  end

`ifdef PC_WRAP_FLAG_EN
  logic wrap_d, wrap_q;
`endif

  pc_next_sel #(
    .STEP (STEP)
  ) u_next_sel (
    .op_i      (op),
    .pc_i      (pc_q),
    .pc_in_i   (bus.PC_in),
`ifdef PC_WRAP_FLAG_EN
    .wrap_o    (wrap_d),
`endif
    .pc_next_o (pc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.PC_out = pc_q;

`ifdef PC_WRAP_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign bus.wrap = wrap_q;
`endif

endmodule

// File: tb/clock_generator.sv
// Simulation-only clock source: toggles every HALF_PERIOD while en=1, parks low when en=0.
module clock_generator #(
  parameter int unsigned HALF_PERIOD = 10
) (
  input  logic en,
  output logic clk
);

  initial begin
    clk = 1'b0;
    forever begin
      #HALF_PERIOD;
      if (en) begin
        clk = ~clk;
      end else begin
        clk = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with a scoreboard queue of expected PC values.
// Build with PC_WRAP_FLAG_EN defined to also check the wrap pulse.
module tb_program_counter;
  import pc_pkg::*;

  logic en;
  logic clk;
  logic rst_a;
  logic rst_b;

  int checks = 0;
  int errors = 0;

  pc_t exp_q[$];
  pc_t model_pc;

  clock_generator #(
    .HALF_PERIOD (10)
  ) u_clk_gen (
    .en  (en),
    .clk (clk)
  );

  program_counter_if bus_a ();
  program_counter_if bus_b ();

  program_counter u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.slave)
  );

  program_counter #(
    .RESET_VEC (16'hFFFE)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.slave)
  );

  task automatic check(input string tag, input pc_t obs, input pc_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of controls on DUT A, push the model result, compare after the edge.
  task automatic step(input logic ld, input logic inc, input pc_in_t pin, input string tag);
    bus_a.LD    = ld;
    bus_a.Inc   = inc;
    bus_a.PC_in = pin;
    if (ld) begin
      model_pc = {8'h00, pin};
    end else if (inc) begin
      model_pc = model_pc + 16'd1;
    end
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, bus_a.PC_out, ~bus_a.PC_out);
    end else begin
      check(tag, bus_a.PC_out, exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    en          = 1'b0;
    rst_a       = 1'b1;
    rst_b       = 1'b1;
    bus_a.LD    = 1'b1;
    bus_a.Inc   = 1'b0;
    bus_a.PC_in = pc_in_t'($urandom);
    bus_b.LD    = 1'b0;
    bus_b.Inc   = 1'b0;
    bus_b.PC_in = 8'h00;
    model_pc    = 16'h0000;

    // Reset with the clock parked: value must appear without any edge.
    #5;
    check("reset_no_clk_a", bus_a.PC_out, 16'h0000);
    check("reset_no_clk_b", bus_b.PC_out, 16'hFFFE);
`ifdef PC_WRAP_FLAG_EN
    check("reset_wrap_a", {15'd0, bus_a.wrap}, 16'h0000);
`endif

    en = 1'b1;
    @(posedge clk);
    #1;
    check("reset_hold_with_ld", bus_a.PC_out, 16'h0000);

    rst_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, pc_in_t'($urandom), "idle_after_reset");
    end

    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 8'h00, "count");
    end
    check("count_end", bus_a.PC_out, 16'h000F);

    step(1'b1, 1'b1, 8'hFF, "load_beats_inc");
    check("load_value", bus_a.PC_out, 16'h00FF);
    step(1'b1, 1'b0, 8'hFF, "load_repeat");
    step(1'b1, 1'b1, 8'hFF, "load_repeat_inc");
`ifdef PC_WRAP_FLAG_EN
    check("no_wrap_on_load", {15'd0, bus_a.wrap}, 16'h0000);
`endif

    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 8'hF0, "hold");
    end

    en = 1'b0;
    #100;
    check("clock_stopped", bus_a.PC_out, 16'h00FF);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("clock_restarted_hold", bus_a.PC_out, 16'h00FF);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h00, "count_pre_reset");
    end
    check("count_pre_reset_end", bus_a.PC_out, 16'h0102);

    // Reset between edges with a load pending: the load must be dropped.
    #4;
    bus_a.LD    = 1'b1;
    bus_a.PC_in = 8'hAB;
    rst_a       = 1'b1;
    #1;
    check("mid_reset_immediate", bus_a.PC_out, 16'h0000);
    @(posedge clk);
    #1;
    check("mid_reset_load_dropped", bus_a.PC_out, 16'h0000);
    rst_a    = 1'b0;
    model_pc = 16'h0000;
    step(1'b0, 1'b1, 8'h00, "resume_count");
    check("resume_first", bus_a.PC_out, 16'h0001);
    step(1'b0, 1'b1, 8'h00, "resume_count");

    // Wrap on the instance whose reset vector is FFFE.
    bus_b.Inc = 1'b1;
    rst_b     = 1'b0;
    @(posedge clk);
    #1;
    check("wrap_ffff", bus_b.PC_out, 16'hFFFF);
`ifdef PC_WRAP_FLAG_EN
    check("wrap_flag_before", {15'd0, bus_b.wrap}, 16'h0000);
`endif
    @(posedge clk);
    #1;
    check("wrap_zero", bus_b.PC_out, 16'h0000);
`ifdef PC_WRAP_FLAG_EN
    check("wrap_flag_pulse", {15'd0, bus_b.wrap}, 16'h0001);
`endif
    @(posedge clk);
    #1;
    check("wrap_after", bus_b.PC_out, 16'h0001);
`ifdef PC_WRAP_FLAG_EN
    check("wrap_flag_cleared", {15'd0, bus_b.wrap}, 16'h0000);
`endif

    check("scoreboard_drained", pc_t'(exp_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
